// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared states, requester ids and default widths for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    // Counter width able to reach TIMEOUT-1; still one bit when TIMEOUT is 0 or 1.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// rtl/mem_port_arbiter_timer.sv - busy-cycle timeout counter with clear, enable and expired flag
module mem_arb_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = timer_width(TIMEOUT);

    logic [CW-1:0] cnt;

    // Clear loads zero on entry to BUSY; enable advances once per busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            // A zero timeout means wait for the memory forever.
            assign expired = 1'b0;
        end else begin : g_timeout
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
            assign expired = (cnt == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for one single-port memory; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err,
    output logic          stall
);

    state_t  state;
    state_t  state_nxt;
    req_id_t owner;
    logic    grant_dm;
    logic    start;
    logic    done;
    logic    timed_out;
    logic    tmr_expired;

`ifdef MEM_ARB_RR_EN
    req_id_t rr_last;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        grant_dm = dm_req;
        if (if_req && dm_req) begin
            grant_dm = (rr_last == REQ_IF);
        end
    end

    // Remember the most recent grant so the other side wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= REQ_IF;
        end else if (start) begin
            rr_last <= grant_dm ? REQ_DM : REQ_IF;
        end
    end
`else
    // DM belongs to the older instruction, so it always wins over IF.
    assign grant_dm = dm_req;
`endif

    // Timeout counter runs only while an access is outstanding.
    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start),
        .en      (state == ST_BUSY),
        .expired (tmr_expired)
    );

    // State register; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the start/done strobes that steer the output registers.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    start     = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready || tmr_expired) begin
                    done      = 1'b1;
                    timed_out = !mem_ready;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Memory bus: latched at grant, held through BUSY, request dropped on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= REQ_IF;
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= grant_dm ? dm_we : 1'b0;
            mem_addr  <= grant_dm ? dm_addr : if_addr;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            owner     <= grant_dm ? REQ_DM : REQ_IF;
        end else if (done) begin
            mem_req   <= 1'b0;
        end
    end

    // Acks and err are single-cycle pulses in the cycle after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            err    <= 1'b0;
        end else begin
            if_ack <= done && (owner == REQ_IF);
            dm_ack <= done && (owner == REQ_DM);
            err    <= done && timed_out;
        end
    end

    // Read data goes to the owner; writes and timed-out accesses return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (done) begin
            if (owner == REQ_DM) begin
                dm_rdata <= (mem_we || timed_out) ? '0 : mem_rdata;
            end else begin
                if_rdata <= timed_out ? '0 : mem_rdata;
            end
        end
    end

    assign stall = (if_req && !if_ack) || (dm_req && !dm_ack);

endmodule
